// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the cache-to-SRAM halfword sequencer.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_BASE_OFFSET = 1024;
    localparam int          READ_HALFWORDS      = 4;
    localparam int          WRITE_HALFWORDS     = 2;
    localparam int          HW_WIDTH            = 16;

endpackage

// File: rtl/sram_dq_buf.sv
// Tri-state pad wrapper for the 16-bit SRAM data bus.
module sram_dq_buf
    import sram_ctrl_pkg::*;
(
    inout  wire  [HW_WIDTH-1:0] dq,
    input  logic                oe,
    input  logic [HW_WIDTH-1:0] dout,
    output logic [HW_WIDTH-1:0] din
);

    assign dq  = oe ? dout : {HW_WIDTH{1'bz}};
    assign din = dq;

endmodule

// File: rtl/sram_controller.sv
// Sequences 32-bit writes and 64-bit block reads as 16-bit asynchronous SRAM cycles.
// Optional out-of-range address rejection is built when SRAM_CTRL_RANGE_CHECK_EN is defined.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter int unsigned BASE_OFFSET   = DEFAULT_BASE_OFFSET
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SRAM_WE_EN,
    input  logic                SRAM_RE_EN,
    input  logic [31:0]         address,
    input  logic [31:0]         writeData,
    output logic                ready,
    output logic [63:0]         readData,
    inout  wire  [HW_WIDTH-1:0] SRAM_DQ,
    output logic [17:0]         SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output state_t              state_dbg
);

    localparam int SLOT_W = $clog2(ACCESS_CYCLES);
    localparam int IDX_W  = $clog2(READ_HALFWORDS);

    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(ACCESS_CYCLES - 1);
    localparam logic [IDX_W-1:0]  RD_IDX_LAST = IDX_W'(READ_HALFWORDS - 1);
    localparam logic [IDX_W-1:0]  WR_IDX_LAST = IDX_W'(WRITE_HALFWORDS - 1);

    state_t                state_q, state_d;
    logic                  is_write_q;
    logic [31:0]           wdata_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [IDX_W-1:0]      idx_q;
    logic [47:0]           rbuf_q;
    logic [63:0]           rdata_q;
    logic [17:0]           addr_q;

    logic [31:0]           gen;
    logic [17:0]           rd_base;
    logic [17:0]           wr_base;
    logic                  req;
    logic                  out_of_range;
    logic                  in_access;
    logic                  slot_last;
    logic                  idx_last;
    logic                  dq_oe;
    logic [HW_WIDTH-1:0]   dq_out;
    logic [HW_WIDTH-1:0]   dq_in;
    logic                  unused_bits;

    assign gen     = {address[31:2], 2'b00} - BASE_OFFSET[31:0];
    assign rd_base = {gen[18:3], 2'b00};
    assign wr_base = {gen[18:2], 1'b0};
    assign req     = SRAM_WE_EN | SRAM_RE_EN;

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    assign out_of_range = (address < BASE_OFFSET[31:0]) || (gen[31:19] != '0);
`else
    assign out_of_range = 1'b0;
`endif

    // Bits outside the 18-bit halfword window are only consulted by the range check.
    assign unused_bits = ^{gen[1:0], gen[31:19], address[1:0]};

    assign in_access = (state_q == ST_ACCESS);
    assign slot_last = (slot_q == SLOT_LAST);
    assign idx_last  = (idx_q == (is_write_q ? WR_IDX_LAST : RD_IDX_LAST));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = out_of_range ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (slot_last && idx_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            slot_q     <= '0;
            idx_q      <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        is_write_q <= SRAM_WE_EN;
                        wdata_q    <= writeData;
                        slot_q     <= '0;
                        idx_q      <= '0;
                        if (!out_of_range) begin
                            addr_q <= SRAM_WE_EN ? wr_base : rd_base;
                        end else if (!SRAM_WE_EN) begin
                            rdata_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (slot_last) begin
                        slot_q <= '0;
                        if (!is_write_q) begin
                            case (idx_q)
                                2'd0:    rbuf_q[15:0]  <= dq_in;
                                2'd1:    rbuf_q[31:16] <= dq_in;
                                2'd2:    rbuf_q[47:32] <= dq_in;
                                default: ;
                            endcase
                        end
                        if (idx_last) begin
                            idx_q <= '0;
                            // The top lane arrives on the same edge that publishes the block.
                            if (!is_write_q) begin
                                rdata_q <= {dq_in, rbuf_q};
                            end
                        end else begin
                            idx_q  <= idx_q + IDX_W'(1);
                            addr_q <= addr_q + 18'd1;
                        end
                    end else begin
                        slot_q <= slot_q + SLOT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Write strobe rises on the final cycle of each slot so data is held past WE_N.
    assign SRAM_CE_N = ~in_access;
    assign SRAM_OE_N = ~(in_access && !is_write_q);
    assign SRAM_WE_N = ~(in_access && is_write_q && !slot_last);
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = addr_q;

    assign dq_oe  = in_access && is_write_q;
    assign dq_out = idx_q[0] ? wdata_q[31:16] : wdata_q[15:0];

    assign ready     = (state_q == ST_DONE);
    assign readData  = rdata_q;
    assign state_dbg = state_q;

    sram_dq_buf u_dq_buf (
        .dq   (SRAM_DQ),
        .oe   (dq_oe),
        .dout (dq_out),
        .din  (dq_in)
    );

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural asynchronous SRAM on the pins.
module tb_sram_controller;
    import sram_ctrl_pkg::*;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_en = 1'b0;
    logic        re_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        ready;
    logic [63:0] read_data;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
    state_t      state_dbg;

    always #5 clk = ~clk;

    sram_controller #(.ACCESS_CYCLES(AC), .BASE_OFFSET(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .SRAM_WE_EN (we_en),
        .SRAM_RE_EN (re_en),
        .address    (address),
        .writeData  (write_data),
        .ready      (ready),
        .readData   (read_data),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .state_dbg  (state_dbg)
    );

    // SRAM model: 256 halfwords, written on the rising edge of WE_N.
    logic [15:0] mem [0:255];
    logic        mon_en = 1'b0;
    logic        tb_drive;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0A00 + 16'(i);
        mem[4] = 16'h1111;
        mem[5] = 16'h2222;
        mem[6] = 16'h3333;
        mem[7] = 16'h4444;
        forever begin
            @(posedge sram_we_n);
            if (mon_en && sram_ce_n == 1'b0) mem[sram_addr[7:0]] = sram_dq;
        end
    end

    assign tb_drive = mon_en && !sram_ce_n && !sram_oe_n;
    assign sram_dq  = tb_drive ? mem[sram_addr[7:0]] : 16'hzzzz;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [33:0] wr_bus_q[$];
    logic [17:0] rd_addr_q[$];

    int          n_vec = 0;
    int          n_miss = 0;
    logic [63:0] rd_model = '0;
    logic        prev_ready = 1'b0;
    int          we_low_cnt = 0;
    int          oe_low_cnt = 0;
    int          ce_low_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents ready or a bus strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready) begin
                check("ready_single_cycle", 64'(prev_ready), 64'd0);
                check("ready_expected", 64'(exp_cyc_q.size() > 0), 64'd1);
                if (exp_cyc_q.size() > 0) begin
                    check("ready_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                    check("read_data", read_data, exp_q.pop_front());
                end
            end
            prev_ready = ready;
            if (!sram_ce_n) ce_low_cnt++;
            if (!sram_we_n) begin
                we_low_cnt++;
                check("wr_bus_expected", 64'(wr_bus_q.size() > 0), 64'd1);
                if (wr_bus_q.size() > 0) check("wr_bus_addr_data", 64'({sram_addr, sram_dq}), 64'(wr_bus_q.pop_front()));
            end
            if (!sram_oe_n) begin
                oe_low_cnt++;
                check("rd_bus_expected", 64'(rd_addr_q.size() > 0), 64'd1);
                if (rd_addr_q.size() > 0) check("rd_bus_addr", 64'(sram_addr), 64'(rd_addr_q.pop_front()));
            end
        end
    end

    task automatic push_read_bus(input logic [17:0] base);
        for (int h = 0; h < 4; h++)
            for (int s = 0; s < AC; s++) rd_addr_q.push_back(base + 18'(h));
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [63:0] exp, input logic [17:0] base);
        @(negedge clk);
        address = a;
        re_en   = 1'b1;
        exp_cyc_q.push_back(cyc + 1 + 4 * AC);
        exp_q.push_back(exp);
        rd_model = exp;
        push_read_bus(base);
        @(negedge clk);
        re_en = 1'b0;
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [17:0] base);
        @(negedge clk);
        address    = a;
        write_data = d;
        we_en      = 1'b1;
        exp_cyc_q.push_back(cyc + 1 + 2 * AC);
        exp_q.push_back(rd_model);
        for (int s = 0; s < AC - 1; s++) wr_bus_q.push_back({base, d[15:0]});
        for (int s = 0; s < AC - 1; s++) wr_bus_q.push_back({base + 18'd1, d[31:16]});
        @(negedge clk);
        we_en = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_cyc_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("completion_in_budget", 64'(exp_cyc_q.size()), 64'd0);
        exp_cyc_q.delete();
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int k;
        int ce_before;

        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_read_data", read_data, 64'd0);
        check("reset_addr", 64'(sram_addr), 64'd0);
        check("reset_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'd7);
        check("reset_lanes", 64'({sram_ub_n, sram_lb_n}), 64'd0);
        check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;

        // Block read from 0x40C: halfwords 4..7.
        oe_low_cnt = 0;
        issue_read(32'h0000_040C, 64'h4444_3333_2222_1111, 18'h004);
        wait_done(40);
        check("read_oe_low_cycles", 64'(oe_low_cnt), 64'd8);

        // Word write to 0x408: halfwords 4 and 5.
        we_low_cnt = 0;
        issue_write(32'h0000_0408, 32'hCAFE_BABE, 18'h004);
        wait_done(40);
        check("write_we_low_cycles", 64'(we_low_cnt), 64'd2);
        check("write_mem_lo", 64'(mem[4]), 64'h0000_0000_0000_BABE);
        check("write_mem_hi", 64'(mem[5]), 64'h0000_0000_0000_CAFE);
        check("addr_hold_after_write", 64'(sram_addr), 64'h005);

        issue_read(32'h0000_0408, 64'h4444_3333_CAFE_BABE, 18'h004);
        wait_done(40);

        // Request held through DONE: second read sampled in the idle cycle after ready.
        @(negedge clk);
        k = cyc;
        address = 32'h0000_0418;
        re_en   = 1'b1;
        exp_cyc_q.push_back(k + 9);
        exp_cyc_q.push_back(k + 19);
        exp_q.push_back(64'h0A0F_0A0E_0A0D_0A0C);
        exp_q.push_back(64'h0A0F_0A0E_0A0D_0A0C);
        push_read_bus(18'h00C);
        push_read_bus(18'h00C);
        while (cyc < k + 11) @(negedge clk);
        re_en = 1'b0;
        rd_model = 64'h0A0F_0A0E_0A0D_0A0C;
        wait_done(60);

        // RE dropped in cycle 3: access still completes.
        @(negedge clk);
        k = cyc;
        address = 32'h0000_0420;
        re_en   = 1'b1;
        exp_cyc_q.push_back(k + 9);
        exp_q.push_back(64'h0A13_0A12_0A11_0A10);
        push_read_bus(18'h010);
        while (cyc < k + 3) @(negedge clk);
        re_en = 1'b0;
        wait_done(40);

        // Reset asserted in cycle 4 of a read: abandon, clear readData, no ready.
        @(negedge clk);
        k = cyc;
        address = 32'h0000_040C;
        re_en   = 1'b1;
        rd_addr_q.push_back(18'h004);
        rd_addr_q.push_back(18'h004);
        rd_addr_q.push_back(18'h005);
        rd_addr_q.push_back(18'h005);
        @(negedge clk);
        re_en = 1'b0;
        while (cyc < k + 4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
        check("abort_ce_n", 64'(sram_ce_n), 64'd1);
        check("abort_oe_n", 64'(sram_oe_n), 64'd1);
        check("abort_read_data", read_data, 64'd0);
        check("abort_addr", 64'(sram_addr), 64'd0);
        rd_model = '0;
        rst = 1'b1;
        repeat (12) @(negedge clk);

        issue_read(32'h0000_040C, 64'h4444_3333_CAFE_BABE, 18'h004);
        wait_done(40);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        // Address below the window: immediate ready, readData cleared, bus untouched.
        ce_before = ce_low_cnt;
        @(negedge clk);
        k = cyc;
        address = 32'h0000_0100;
        re_en   = 1'b1;
        exp_cyc_q.push_back(k + 1);
        exp_q.push_back(64'd0);
        @(negedge clk);
        re_en = 1'b0;
        rd_model = '0;
        wait_done(20);
        check("range_ce_never_low", 64'(ce_low_cnt), 64'(ce_before));
`else
        ce_before = ce_low_cnt;
        check("ce_idle_between_ops", 64'(sram_ce_n), 64'd1);
`endif

        check("wr_bus_drained", 64'(wr_bus_q.size()), 64'd0);
        check("rd_bus_drained", 64'(rd_addr_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
